// File: rtl/i2c_bus_conditioner.sv
// i2c_bus_conditioner
//   Pad-side front end for the I2C-to-Wishbone bridge.
//   - two-flop synchronizer plus glitch filter on SCL and SDA
//   - START / STOP detection with a bus-busy flag
//   - SCL-low supervision with a programmable, sticky timeout
//   - out/oe pairs from the bridge turned into open-drain pull-down enables
//
// Ports
//   clk_i, rst_i              : clock, async active-low reset
//   scl_pad_i, sda_pad_i      : raw pad inputs
//   scl_o, sda_o              : filtered lines to the bridge
//   scl_out_i/scl_oe_i,
//   sda_out_i/sda_oe_i        : bridge drive level / enable
//   scl_pad_oe_o, sda_pad_oe_o: pad pull-down enables (pad value tied to 0)
//   start_o, stop_o           : one-cycle condition pulses
//   busy_o                    : bus busy between START and STOP/timeout
//   to_limit_i                : SCL-low timeout in clk_i cycles, 0 = off
//   timeout_o, to_clr_i       : sticky timeout flag and its clear

// Per-line synchronizer and glitch filter. The filtered level only moves
// once the synced input has disagreed with it for FILT_LEN cycles in a row.
module i2c_glitch_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  output logic line_o
);
  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync   <= 2'b11;
      cnt    <= '0;
      line_o <= 1'b1;
    end else begin
      sync <= {sync[0], pad_i};
      if (sync[1] == line_o) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        line_o <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module i2c_bus_conditioner #(
  parameter int FILT_LEN = 3,
  parameter int TO_W     = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            scl_pad_i,
  input  logic            sda_pad_i,
  output logic            scl_o,
  output logic            sda_o,
  input  logic            scl_out_i,
  input  logic            scl_oe_i,
  input  logic            sda_out_i,
  input  logic            sda_oe_i,
  output logic            scl_pad_oe_o,
  output logic            sda_pad_oe_o,
  output logic            start_o,
  output logic            stop_o,
  output logic            busy_o,
  input  logic [TO_W-1:0] to_limit_i,
  output logic            timeout_o,
  input  logic            to_clr_i
);
  // line index 0 = SCL, 1 = SDA
  logic [1:0] pad_raw;
  logic [1:0] line_f;

  assign pad_raw = {sda_pad_i, scl_pad_i};

  for (genvar g = 0; g < 2; g++) begin : g_line
    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .pad_i  (pad_raw[g]),
      .line_o (line_f[g])
    );
  end

  assign scl_o = line_f[0];
  assign sda_o = line_f[1];

  // Open-drain: only pull low when the bridge actively drives a 0.
  assign scl_pad_oe_o = scl_oe_i & ~scl_out_i;
  assign sda_pad_oe_o = sda_oe_i & ~sda_out_i;

  logic            scl_d, sda_d;
  logic            start_c, stop_c;
  logic            stall, to_evt;
  logic [TO_W-1:0] tcnt;

  // SDA moving while SCL is high and stable across both samples. A
  // simultaneous SCL edge fails the scl_d & scl_o term, so it is ignored.
  assign start_c = scl_d & scl_o &  sda_d & ~sda_o;
  assign stop_c  = scl_d & scl_o & ~sda_d &  sda_o;

  // tcnt counts cycles SCL has already been low while busy; the event fires
  // on the last cycle so timeout_o rises exactly to_limit_i cycles in.
  assign stall  = busy_o & ~scl_o & (to_limit_i != '0);
  assign to_evt = stall & (tcnt == to_limit_i - TO_W'(1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      start_o   <= 1'b0;
      stop_o    <= 1'b0;
      busy_o    <= 1'b0;
      tcnt      <= '0;
      timeout_o <= 1'b0;
    end else begin
      scl_d   <= scl_o;
      sda_d   <= sda_o;
      start_o <= start_c;
      stop_o  <= stop_c;

      // START needs SCL high, timeout needs SCL low: never both at once.
      if (start_c)                busy_o <= 1'b1;
      else if (stop_c || to_evt)  busy_o <= 1'b0;

      if (!stall)             tcnt <= '0;
      else if (tcnt != '1)    tcnt <= tcnt + 1'b1;

      if (to_evt)             timeout_o <= 1'b1;
      else if (to_clr_i)      timeout_o <= 1'b0;
    end
  end
endmodule
